// File: rtl/jingle_pkg.sv
`default_nettype none
//==============================================================================
// Module      : jingle_pkg
// Description : Shared types and constants for the jingle sequencer:
//               note-code to Hz table, FSM state encoding, jingle IDs and
//               the melody ROM entry layout.
// Revision    : 1.0 - initial release
//==============================================================================
package jingle_pkg;

    // Note code -> frequency in Hz. Code 0 is silence; unused codes are silent.
    localparam logic [31:0] NOTE_HZ [16] = '{
        32'd0,   32'd262, 32'd330, 32'd392,
        32'd523, 32'd659, 32'd784, 32'd0,
        32'd0,   32'd0,   32'd0,   32'd0,
        32'd0,   32'd0,   32'd0,   32'd0
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        START = 1'b0,
        OVER  = 1'b1
    } jingle_id_t;

    typedef struct packed {
        logic [3:0] code;   // index into NOTE_HZ
        logic [4:0] dur;    // note length in ticks, 1..31
        logic       last;   // final note of the jingle
    } rom_entry_t;

endpackage : jingle_pkg
`default_nettype wire

// File: rtl/jingle_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module      : jingle_sequencer_if
// Description : Event/audio bundle between the game FSM (master) and the
//               jingle sequencer (slave).
//   trig_start : 1-cycle pulse, request START jingle   (master -> slave)
//   trig_over  : 1-cycle pulse, request OVER jingle    (master -> slave)
//   freq[31:0] : current note frequency in Hz, 0=silent (slave -> master)
//   busy       : jingle in progress                    (slave -> master)
//   done       : 1-cycle pulse when a jingle ends      (slave -> master)
//   step[1:0]  : index of the note being played        (slave -> master)
// Revision    : 1.0 - initial release
//==============================================================================
interface jingle_sequencer_if;
    logic        trig_start;
    logic        trig_over;
    logic [31:0] freq;
    logic        busy;
    logic        done;
    logic [1:0]  step;

    modport master (
        output trig_start, trig_over,
        input  freq, busy, done, step
    );

    modport slave (
        input  trig_start, trig_over,
        output freq, busy, done, step
    );
endinterface : jingle_sequencer_if
`default_nettype wire

// File: rtl/jingle_rom.sv
`default_nettype none
//==============================================================================
// Module      : jingle_rom
// Description : Combinational melody table, (jingle, step) -> {code, dur, last}.
//   jingle     : jingle ID (START / OVER)
//   step[1:0]  : note index within the jingle
//   entry      : note code, duration in ticks, last-note flag
// Revision    : 1.0 - initial release
//==============================================================================
module jingle_rom
    import jingle_pkg::*;
(
    input  jingle_id_t jingle,
    input  logic [1:0] step,
    output rom_entry_t entry
);

    always_comb begin
        entry = '{code: 4'd0, dur: 5'd1, last: 1'b1};
        case ({jingle, step})
            {START, 2'd0}: entry = '{code: 4'd4, dur: 5'd10, last: 1'b0};
            {START, 2'd1}: entry = '{code: 4'd5, dur: 5'd10, last: 1'b0};
            {START, 2'd2}: entry = '{code: 4'd6, dur: 5'd20, last: 1'b1};
            {OVER,  2'd0}: entry = '{code: 4'd3, dur: 5'd15, last: 1'b0};
            {OVER,  2'd1}: entry = '{code: 4'd2, dur: 5'd15, last: 1'b0};
            {OVER,  2'd2}: entry = '{code: 4'd1, dur: 5'd30, last: 1'b1};
            default:       entry = '{code: 4'd0, dur: 5'd1,  last: 1'b1};
        endcase
    end

endmodule : jingle_rom
`default_nettype wire

// File: rtl/jingle_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : jingle_sequencer
// Description : Event-driven note sequencer. Plays a short fixed melody on a
//               game event and presents the note frequency (Hz) to the PWM
//               stage. OVER preempts anything; START is ignored while busy.
// Parameters  : CLK_HZ    - system clock frequency
//               TICK_HZ   - duration tick rate (TICK_DIV = CLK_HZ/TICK_HZ >= 2)
//               GAP_TICKS - silent gap between notes (gap build only)
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-low
//               bus   - jingle_sequencer_if.slave (triggers in, freq/busy/
//                       done/step out, all registered)
// Build macro : JINGLE_GAP_EN - when defined, a GAP_TICKS silence separates
//               consecutive notes.
// Revision    : 1.0 - initial release
//==============================================================================
module jingle_sequencer
    import jingle_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int GAP_TICKS = 1
) (
    input  logic                clk,
    input  logic                reset,
    jingle_sequencer_if.slave   bus
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("jingle_sequencer: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_gap_ticks
        $error("jingle_sequencer: GAP_TICKS must be in 1..255");
    end

    // Registered state
    state_t            r_state;
    jingle_id_t        r_jingle;
    logic [1:0]        r_step;
    logic [4:0]        r_dur_cnt;
    logic              r_last;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [31:0]       r_freq;
    logic              r_busy;
    logic              r_done;

    // Next-state / control
    state_t            w_state_next;
    jingle_id_t        w_jingle_next;
    logic [1:0]        w_step_next;
    logic              w_load;      // load duration/last for the new note
    logic              w_dur_dec;
    logic              w_tick_clr;
    logic              w_preempt;
    logic              w_tick;
    rom_entry_t        w_entry;
    logic [4:0]        w_dur_load;

`ifdef JINGLE_GAP_EN
    localparam logic [7:0] c_gap_init = 8'(GAP_TICKS);
    logic [7:0]        r_gap_cnt;
    logic [7:0]        w_gap_next;
`endif

    assign w_tick = (r_tick_cnt == c_tick_last);

    // ROM looks at the step being entered, so the new note's code and
    // duration are ready to register at the same edge as the transition.
    jingle_rom u_rom (
        .jingle (w_jingle_next),
        .step   (w_step_next),
        .entry  (w_entry)
    );

    always_comb begin
        w_state_next  = r_state;
        w_jingle_next = r_jingle;
        w_step_next   = r_step;
        w_load        = 1'b0;
        w_dur_dec     = 1'b0;
        w_tick_clr    = 1'b0;
        w_preempt     = 1'b0;
`ifdef JINGLE_GAP_EN
        w_gap_next    = r_gap_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (bus.trig_over) begin
                    w_state_next  = PLAY;
                    w_jingle_next = OVER;
                    w_step_next   = 2'd0;
                    w_load        = 1'b1;
                    w_tick_clr    = 1'b1;
                end else if (bus.trig_start) begin
                    w_state_next  = PLAY;
                    w_jingle_next = START;
                    w_step_next   = 2'd0;
                    w_load        = 1'b1;
                    w_tick_clr    = 1'b1;
                end
            end
            PLAY: begin
                if (w_tick) begin
                    // Counter holds the ticks remaining including this one,
                    // so the note ends on the tick that sees 1 (or an illegal 0).
                    if (r_dur_cnt <= 5'd1) begin
                        if (r_last) begin
                            w_state_next = DONE;
                        end else begin
`ifdef JINGLE_GAP_EN
                            w_state_next = GAP;
                            w_gap_next   = c_gap_init;
                            w_tick_clr   = 1'b1;
`else
                            w_step_next  = r_step + 2'd1;
                            w_load       = 1'b1;
                            w_tick_clr   = 1'b1;
`endif
                        end
                    end else begin
                        w_dur_dec = 1'b1;
                    end
                end
            end
`ifdef JINGLE_GAP_EN
            GAP: begin
                if (w_tick) begin
                    if (r_gap_cnt <= 8'd1) begin
                        w_state_next = PLAY;
                        w_step_next  = r_step + 2'd1;
                        w_load       = 1'b1;
                        w_tick_clr   = 1'b1;
                    end else begin
                        w_gap_next = r_gap_cnt - 8'd1;
                    end
                end
            end
`endif
            DONE: begin
                w_state_next = IDLE;
                w_step_next  = 2'd0;
            end
            default: begin
                w_state_next = IDLE;
                w_step_next  = 2'd0;
            end
        endcase

        // OVER restarts from any busy state, overriding the normal flow.
        if (r_state != IDLE && bus.trig_over) begin
            w_state_next  = PLAY;
            w_jingle_next = OVER;
            w_step_next   = 2'd0;
            w_load        = 1'b1;
            w_dur_dec     = 1'b0;
            w_tick_clr    = 1'b1;
            w_preempt     = 1'b1;
        end
    end

    // Duration code 0 is illegal in the ROM; play it as a single tick.
    always_comb begin
        w_dur_load = (w_entry.dur == 5'd0) ? 5'd1 : w_entry.dur;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_jingle   <= START;
            r_step     <= 2'd0;
            r_dur_cnt  <= 5'd0;
            r_last     <= 1'b0;
            r_tick_cnt <= '0;
            r_freq     <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_jingle <= w_jingle_next;
            r_step   <= w_step_next;
            if (w_load) begin
                r_dur_cnt <= w_dur_load;
                r_last    <= w_entry.last;
            end else if (w_dur_dec) begin
                r_dur_cnt <= r_dur_cnt - 5'd1;
            end
            if (w_tick_clr || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            r_freq <= (w_state_next == PLAY) ? NOTE_HZ[w_entry.code] : 32'd0;
            r_busy <= (w_state_next != IDLE);
            r_done <= (w_state_next == DONE) || w_preempt;
        end
    end

`ifdef JINGLE_GAP_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gap_cnt <= 8'd0;
        end else begin
            r_gap_cnt <= w_gap_next;
        end
    end
`endif

    assign bus.freq = r_freq;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.step = r_step;

endmodule : jingle_sequencer
`default_nettype wire

// File: tb/tb_jingle_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_jingle_sequencer
// Description : Self-checking bench for jingle_sequencer. Stimulus pushes the
//               expected output as run-length segments {freq,busy,done,step,
//               cycles}; a monitor compares each output change against the
//               next segment and checks each segment's length on exit.
//               Honours JINGLE_GAP_EN the same way as the design.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_jingle_sequencer;

    localparam int TICK_DIV = 10;
`ifdef JINGLE_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef struct {
        int unsigned f;
        bit          busy;
        bit          done;
        int          step;
        int          len;    // 0 = open-ended (idle), length not checked
    } seg_t;

    logic clk;
    logic reset;
    jingle_sequencer_if bus ();

    jingle_sequencer #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .GAP_TICKS (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   seg_no = 0;

    // Melody tables written out by hand.
    int unsigned start_hz [3] = '{523, 659, 784};
    int          start_dur[3] = '{10, 10, 20};
    int unsigned over_hz  [3] = '{392, 330, 262};
    int          over_dur [3] = '{15, 15, 30};

    task automatic push_seg(input int unsigned f, input bit b, input bit d,
                            input int s, input int len);
        seg_t e;
        e.f = f; e.busy = b; e.done = d; e.step = s; e.len = len;
        q.push_back(e);
    endtask

    // Full jingle from step 0 to idle; lead_done marks a preempting start.
    task automatic push_jingle(input bit is_over, input bit lead_done);
        for (int i = 0; i < 3; i++) begin
            int unsigned f;
            int n;
            f = is_over ? over_hz[i] : start_hz[i];
            n = (is_over ? over_dur[i] : start_dur[i]) * TICK_DIV;
            if (i == 0 && lead_done) begin
                push_seg(f, 1'b1, 1'b1, 0, 1);
                push_seg(f, 1'b1, 1'b0, 0, n - 1);
            end else begin
                push_seg(f, 1'b1, 1'b0, i, n);
            end
            if (GAP_ON && i < 2) push_seg(0, 1'b1, 1'b0, i, TICK_DIV);
        end
        push_seg(0, 1'b1, 1'b1, 2, 1);
        push_seg(0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: triggers are sampled by the next rising edge.
    task automatic pulse(input logic s, input logic o);
        bus.trig_start = s;
        bus.trig_over  = o;
        @(negedge clk);
        bus.trig_start = 1'b0;
        bus.trig_over  = 1'b0;
    endtask

    // Monitor
    bit mon_stop = 1'b0;
    initial begin
        seg_t cur, prev, exp;
        bit   have;
        int   run;
        have = 1'b0;
        run  = 0;
        exp  = '{f: 0, busy: 1'b0, done: 1'b0, step: 0, len: 0};
        prev = exp;
        @(posedge clk);
        while (!mon_stop) begin
            @(negedge clk);
            cur.f = bus.freq; cur.busy = bus.busy; cur.done = bus.done;
            cur.step = int'(bus.step); cur.len = 0;
            if (!have || cur.f != prev.f || cur.busy != prev.busy ||
                cur.done != prev.done || cur.step != prev.step) begin
                if (have && exp.len != 0) begin
                    checks++;
                    if (run != exp.len) begin
                        errors++;
                        $display("FAIL seg%0d length: got %0d cycles, expected %0d",
                                 seg_no, run, exp.len);
                    end
                end
                seg_no++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL seg%0d unexpected change: freq=%0d busy=%0b done=%0b step=%0d",
                             seg_no, cur.f, cur.busy, cur.done, cur.step);
                    exp = cur;
                end else begin
                    exp = q.pop_front();
                    if (cur.f != exp.f || cur.busy != exp.busy ||
                        cur.done != exp.done || cur.step != exp.step) begin
                        errors++;
                        $display("FAIL seg%0d outputs: got freq=%0d busy=%0b done=%0b step=%0d, expected freq=%0d busy=%0b done=%0b step=%0d",
                                 seg_no, cur.f, cur.busy, cur.done, cur.step,
                                 exp.f, exp.busy, exp.done, exp.step);
                    end
                end
                have = 1'b1;
                run  = 1;
                prev = cur;
            end else begin
                run++;
            end
        end
    end

    // Stimulus
    initial begin
        reset          = 1'b0;
        bus.trig_start = 1'b0;
        bus.trig_over  = 1'b0;
        push_seg(0, 1'b0, 1'b0, 0, 0);         // reset state
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(3);

        // 1: reset in the middle of the first note, no done pulse.
        push_seg(523, 1'b1, 1'b0, 0, 30);
        push_seg(0, 1'b0, 1'b0, 0, 0);
        pulse(1'b1, 1'b0);
        wait_cyc(29);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        wait_cyc(5);

        // 2: plain START jingle.
        push_jingle(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_cyc(450);

        // 3: OVER preempts START at cycle 50 of the first note.
        push_seg(523, 1'b1, 1'b0, 0, 50);
        push_jingle(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        wait_cyc(49);
        pulse(1'b0, 1'b1);
        wait_cyc(700);

        // 4: START while busy is ignored (during a note and during gap/next note).
        push_jingle(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_cyc(29);
        pulse(1'b1, 1'b0);
        wait_cyc(74);
        pulse(1'b1, 1'b0);
        wait_cyc(350);

        // 5: both triggers from idle -> OVER; OVER retriggers itself at cycle 20.
        push_seg(392, 1'b1, 1'b0, 0, 20);
        push_jingle(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        wait_cyc(19);
        pulse(1'b0, 1'b1);
        wait_cyc(700);

        mon_stop = 1'b1;
        wait_cyc(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d segments left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog timeout");
    end

endmodule : tb_jingle_sequencer
`default_nettype wire
